axil_lite_master: RTL and testbench

- AXI4-Lite initiator that turns single-beat command requests from local control logic into AXI4-Lite write or read transactions.
- Intended to drive the camera-control register slave (xdma_ack / cam_en / cam_addr registers at BASE 0x8000_0000) from on-chip sequencers and self-test logic, without going through XDMA.
- Exactly one outstanding transaction at a time.
- Returns read data and response code on a valid/ready response channel.

---
 rtl/axil_lite_master_pkg.sv | 35 +++
 rtl/axil_lite_master_if.sv | 33 +++
 rtl/axil_lite_master.sv | 126 ++++++++++++
 tb/tb_axil_lite_master.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_lite_master_pkg.sv
// axil_lite_master_pkg: shared state encoding, AXI response codes and camera register map
package axil_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR      = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_ADDR = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;
    localparam logic [2:0] ST_RSP     = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        WR      = ST_WR,
        WR_RESP = ST_WR_RESP,
        RD_ADDR = ST_RD_ADDR,
        RD_DATA = ST_RD_DATA,
        RSP     = ST_RSP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] CAM_BASE       = 32'h8000_0000;
    localparam logic [31:0] REG_ACK        = 32'h0;
    localparam logic [31:0] REG_CAM_EN     = 32'h4;
    localparam logic [31:0] REG_CAM_ADDR_1 = 32'h8;
    localparam logic [31:0] REG_CAM_ADDR_2 = 32'hC;

    // Absolute byte address of a camera-control register.
    function automatic logic [31:0] cam_reg(input logic [31:0] off);
        return CAM_BASE | off;
    endfunction

endpackage

// File: rtl/axil_lite_master_if.sv
// axil_lite_master_if: AXI4-Lite bus bundle with master/slave views
interface axil_lite_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                awvalid;
    logic                awready;
    logic [ADDR_W-1:0]   awaddr;
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;
    logic                arvalid;
    logic                arready;
    logic [ADDR_W-1:0]   araddr;
    logic                rvalid;
    logic                rready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_lite_master.sv
// axil_lite_master: single-outstanding AXI4-Lite initiator; watchdog enabled by AXIL_TIMEOUT_EN
module axil_lite_master
    import axil_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_wdata,
    input  logic [3:0]         cmd_wstrb,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic [1:0]         rsp_resp,
    output logic               busy,
    axil_lite_master_if.master m_axi
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_done, w_done;
    logic              accept, active, aw_ok, w_ok, tmo;

    // Four-bit strobes only cover a 32-bit bus; the watchdog counter is 16 bits wide.
    if (DATA_W != 32 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_param_chk
        $error("axil_lite_master: DATA_W must be 32 and TIMEOUT_CYCLES within 2..65536");
    end

    assign cmd_ready = (state == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = state != IDLE;
    assign rsp_valid = state == RSP;
    assign active    = state inside {WR, WR_RESP, RD_ADDR, RD_DATA};

    // AW and W complete independently; a channel counts as done once its handshake has happened.
    assign aw_ok = aw_done || m_axi.awready;
    assign w_ok  = w_done || m_axi.wready;

    assign m_axi.awvalid = (state == WR) && !aw_done;
    assign m_axi.wvalid  = (state == WR) && !w_done;
    assign m_axi.bready  = state == WR_RESP;
    assign m_axi.arvalid = state == RD_ADDR;
    assign m_axi.rready  = state == RD_DATA;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;

`ifdef AXIL_TIMEOUT_EN
    logic [15:0] cnt;

    // Watchdog restarts with every accepted command and runs while a transaction is open.
    always_ff @(posedge clk) begin
        if (rst || accept) cnt <= '0;
        else if (active) cnt <= cnt + 16'd1;
    end

    // >= keeps the abort sticky if a channel handshake raced the limit.
    assign tmo = active && (cnt >= 16'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // Next-state logic; a real slave response wins over a simultaneous watchdog abort.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (cmd_write ? WR : RD_ADDR) : IDLE;
            WR:      state_n = (aw_ok && w_ok) ? WR_RESP : tmo ? RSP : WR;
            WR_RESP: state_n = (m_axi.bvalid || tmo) ? RSP : WR_RESP;
            RD_ADDR: state_n = m_axi.arready ? RD_DATA : tmo ? RSP : RD_ADDR;
            RD_DATA: state_n = (m_axi.rvalid || tmo) ? RSP : RD_DATA;
            RSP:     state_n = rsp_ready ? IDLE : RSP;
            default: state_n = IDLE;
        endcase
    end

    // Command capture, per-channel completion flags and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (state == WR) begin
                aw_done <= aw_ok;
                w_done  <= w_ok;
            end
            if (state == WR_RESP && m_axi.bvalid) begin
                rsp_rdata <= '0;
                rsp_resp  <= m_axi.bresp;
            end else if (state == RD_DATA && m_axi.rvalid) begin
                rsp_rdata <= m_axi.rdata;
                rsp_resp  <= m_axi.rresp;
            end else if (tmo) begin
                rsp_rdata <= '0;
                rsp_resp  <= RESP_DECERR;
            end
        end
    end

endmodule

// File: tb/tb_axil_lite_master.sv
// tb_axil_lite_master: scoreboard bench for axil_lite_master with a configurable camera-register slave
module tb_axil_lite_master;
    import axil_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        cmd_ready, rsp_valid, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    axil_lite_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axil_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .busy(busy), .m_axi(bus)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // ---------------- slave model ----------------
    int          w_delay = 0, r_delay = 1;
    logic        b_hold = 1'b0, ar_block = 1'b0;
    logic [31:0] regs [4];
    logic        aw_got, w_got, b_pend, r_pend;
    int          wcnt, rcnt;
    logic [31:0] sa, sd;
    logic [3:0]  ss;

    function automatic logic in_rng(input logic [31:0] a);
        return a[31:4] == CAM_BASE[31:4];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    assign bus.awready = !aw_got && bus.awvalid && bus.wvalid;
    assign bus.wready  = !w_got && bus.wvalid && (w_delay == 0 ? bus.awvalid : (aw_got && wcnt >= w_delay));
    assign bus.arready = bus.arvalid && !ar_block && !r_pend && !bus.rvalid;

    always @(posedge clk) begin
        logic [31:0] a, d;
        logic [3:0]  s;
        if (rst) begin
            aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0; wcnt <= 0; rcnt <= 0;
            bus.bvalid <= 0; bus.bresp <= 0; bus.rvalid <= 0; bus.rdata <= 0; bus.rresp <= 0;
            sa <= 0; sd <= 0; ss <= 0;
            for (int i = 0; i < 4; i++) regs[i] <= 0;
        end else begin
            if (bus.awvalid && bus.awready) begin
                aw_got <= 1; sa <= bus.awaddr; wcnt <= 1;
            end else if (aw_got) wcnt <= wcnt + 1;
            if (bus.wvalid && bus.wready) begin
                w_got <= 1; sd <= bus.wdata; ss <= bus.wstrb;
            end
            if ((aw_got || (bus.awvalid && bus.awready)) && (w_got || (bus.wvalid && bus.wready))) begin
                a = aw_got ? sa : bus.awaddr;
                d = w_got ? sd : bus.wdata;
                s = w_got ? ss : bus.wstrb;
                if (in_rng(a)) regs[a[3:2]] <= merge(regs[a[3:2]], d, s);
                bus.bresp <= in_rng(a) ? RESP_OKAY : RESP_SLVERR;
                if (b_hold) b_pend <= 1; else bus.bvalid <= 1;
                aw_got <= 0; w_got <= 0;
            end
            if (b_pend && !b_hold) begin bus.bvalid <= 1; b_pend <= 0; end
            if (bus.bvalid && bus.bready) bus.bvalid <= 0;
            if (bus.arvalid && bus.arready) begin
                bus.rdata <= in_rng(bus.araddr) ? regs[bus.araddr[3:2]] : 32'hDEAD_BEEF;
                bus.rresp <= in_rng(bus.araddr) ? RESP_OKAY : RESP_SLVERR;
                if (r_delay <= 1) bus.rvalid <= 1;
                else begin r_pend <= 1; rcnt <= 2; end
            end
            if (r_pend) begin
                if (rcnt >= r_delay) begin bus.rvalid <= 1; r_pend <= 0; end
                else rcnt <= rcnt + 1;
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int   aw_hs_cyc, w_hs_cyc, ar_hs_cyc, rsp_first_cyc, rsp_hs_cyc;
    int   b_hs_n = 0, rsp_n = 0, ar_hi_n = 0, w_alone_n = 0, cr_busy_n = 0, hold_n = 0;
    logic rsp_seen = 1'b0;

    always @(negedge clk) begin
        if (rst) rsp_seen = 1'b0;
        else begin
            if (bus.awvalid && bus.awready) aw_hs_cyc = cyc;
            if (bus.wvalid && bus.wready) w_hs_cyc = cyc;
            if (bus.bvalid && bus.bready) b_hs_n++;
            if (bus.arvalid && bus.arready) ar_hs_cyc = cyc;
            if (bus.arvalid) ar_hi_n++;
            if (bus.wvalid && !bus.awvalid) w_alone_n++;
            if (busy && cmd_ready) cr_busy_n++;
            if (rsp_valid && !rsp_ready) hold_n++;
            if (rsp_valid) begin
                if (!rsp_seen) rsp_first_cyc = cyc;
                if (exp_q.size() == 0) chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
                else begin
                    chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                    chk("rsp_resp", {30'b0, rsp_resp}, {30'b0, exp_q[0].resp});
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        rsp_n++;
                        rsp_hs_cyc = cyc;
                    end
                end
            end
            rsp_seen = rsp_valid;
        end
    end

    // ---------------- driver ----------------
    // Entered and left just after a rising edge; acc is the cycle in which the handshake occurs.
    task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic push, input logic [31:0] er, input logic [1:0] ep, output int acc);
        int n = 0;
        acc = -1;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            if (++n > 200) begin
                chk("cmd_accept_timeout", 32'd0, 32'd1);
                cmd_valid = 0;
                return;
            end
        end
        acc = cyc;
        if (push) exp_q.push_back('{rdata: er, resp: ep});
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            if (++n > 500) begin chk("idle_timeout", 32'd0, 32'd1); break; end
        end while (exp_q.size() != 0 || busy);
        @(posedge clk); #1;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_awvalid"}, {31'b0, bus.awvalid}, 0);
        chk({nm, "_wvalid"}, {31'b0, bus.wvalid}, 0);
        chk({nm, "_bready"}, {31'b0, bus.bready}, 0);
        chk({nm, "_arvalid"}, {31'b0, bus.arvalid}, 0);
        chk({nm, "_rready"}, {31'b0, bus.rready}, 0);
        chk({nm, "_rsp_valid"}, {31'b0, rsp_valid}, 0);
        chk({nm, "_busy"}, {31'b0, busy}, 0);
        chk({nm, "_cmd_ready"}, {31'b0, cmd_ready}, 0);
        chk({nm, "_awaddr"}, bus.awaddr, 0);
        chk({nm, "_araddr"}, bus.araddr, 0);
        chk({nm, "_wdata"}, bus.wdata, 0);
        chk({nm, "_wstrb"}, {28'b0, bus.wstrb}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, n0, n1, n2, n3;
        int t;
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_resp", {30'b0, rsp_resp}, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("idle_cmd_ready", {31'b0, cmd_ready}, 1);
        @(posedge clk); #1;

        // zero-wait writes, back to back
        do_cmd(1, cam_reg(REG_CAM_EN), 32'h1, 4'hF, 1, 32'h0, RESP_OKAY, a1);
        do_cmd(1, cam_reg(REG_CAM_ADDR_2), 32'h1122_3344, 4'hF, 1, 32'h0, RESP_OKAY, a2);
        chk("wr_rsp_latency", rsp_first_cyc - a1, 3);
        chk("cmd_period", a2 - a1, 4);
        wait_idle();
        chk("wr2_aw_latency", aw_hs_cyc - a2, 1);
        chk("wr2_w_latency", w_hs_cyc - a2, 1);
        chk("wr2_rsp_latency", rsp_first_cyc - a2, 3);
        chk("cam_en_reg", regs[1], 32'h1);
        chk("cam_addr2_reg", regs[3], 32'h1122_3344);

        // W accepted three cycles after AW
        w_delay = 3;
        n0 = w_alone_n; n1 = b_hs_n; n2 = rsp_n;
        do_cmd(1, cam_reg(REG_CAM_ADDR_1), 32'h1234_5678, 4'hF, 1, 32'h0, RESP_OKAY, a1);
        wait_idle();
        w_delay = 0;
        chk("split_aw_cycle", aw_hs_cyc - a1, 1);
        chk("split_w_cycle", w_hs_cyc - a1, 4);
        chk("split_w_alone", w_alone_n - n0, 3);
        chk("split_b_count", b_hs_n - n1, 1);
        chk("split_rsp_count", rsp_n - n2, 1);
        chk("cam_addr1_reg", regs[2], 32'h1234_5678);

        // read with rvalid two cycles after AR
        r_delay = 2;
        n0 = cr_busy_n;
        do_cmd(0, cam_reg(REG_CAM_ADDR_1), 32'hFFFF_FFFF, 4'hF, 1, 32'h1234_5678, RESP_OKAY, a1);
        wait_idle();
        r_delay = 1;
        chk("rd_ar_cycle", ar_hs_cyc - a1, 1);
        chk("rd_rsp_after_ar", rsp_first_cyc - ar_hs_cyc, 3);
        chk("rd_cmd_ready_busy", cr_busy_n - n0, 0);

        // partial strobes and out-of-range accesses
        do_cmd(1, cam_reg(REG_CAM_ADDR_2), 32'hAABB_CCDD, 4'h5, 1, 32'h0, RESP_OKAY, a1);
        do_cmd(0, cam_reg(REG_CAM_ADDR_2), 32'h0, 4'h0, 1, 32'h11BB_33DD, RESP_OKAY, a1);
        do_cmd(1, 32'h9000_0000, 32'h5555_5555, 4'hF, 1, 32'h0, RESP_SLVERR, a1);
        do_cmd(0, 32'h9000_0004, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, RESP_SLVERR, a1);
        wait_idle();

        // response held off for five cycles; next command waits for the handshake
        rsp_ready = 0;
        n0 = hold_n;
        fork
            begin
                do_cmd(1, cam_reg(REG_ACK), 32'h0000_00A5, 4'hF, 1, 32'h0, RESP_OKAY, a1);
                do_cmd(0, cam_reg(REG_CAM_EN), 32'h0, 4'h0, 1, 32'h1, RESP_OKAY, a2);
            end
            begin
                t = 0;
                do begin @(negedge clk); t++; end while (!rsp_valid && t < 50);
                repeat (4) @(negedge clk);
                @(posedge clk); #1 rsp_ready = 1;
            end
        join
        chk("hold_next_accept", a2 - rsp_hs_cyc, 1);
        wait_idle();
        chk("hold_cycles", hold_n - n0, 5);
        chk("ack_reg", regs[0], 32'hA5);

        // reset while waiting for B
        b_hold = 1;
        n3 = rsp_n;
        do_cmd(1, cam_reg(REG_CAM_EN), 32'h0, 4'hF, 0, 32'h0, RESP_OKAY, a1);
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.bready && t < 50);
        chk("mid_wr_resp_reached", {31'b0, bus.bready}, 1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk_quiet("midrst");
        @(posedge clk); #1 rst = 0; b_hold = 0;
        @(negedge clk);
        chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 1);
        chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 0);
        @(posedge clk); #1;
        chk("post_rst_no_rsp", rsp_n - n3, 0);
        do_cmd(1, cam_reg(REG_CAM_EN), 32'h3, 4'hF, 1, 32'h0, RESP_OKAY, a1);
        do_cmd(0, cam_reg(REG_CAM_EN), 32'h0, 4'h0, 1, 32'h3, RESP_OKAY, a1);
        wait_idle();

`ifdef AXIL_TIMEOUT_EN
        // slave never accepts AR; watchdog aborts after 16 cycles
        ar_block = 1;
        n0 = ar_hi_n;
        do_cmd(0, cam_reg(REG_ACK), 32'h0, 4'h0, 1, 32'h0, RESP_DECERR, a1);
        wait_idle();
        ar_block = 0;
        chk("tmo_arvalid_cycles", ar_hi_n - n0, 16);
        do_cmd(0, cam_reg(REG_CAM_EN), 32'h0, 4'h0, 1, 32'h3, RESP_OKAY, a1);
        wait_idle();
`endif

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
